visaccum: RTL and testbench



---
 rtl/visaccum_pkg.sv | 34 +++
 rtl/visaccum_visram.sv | 38 +++
 rtl/visaccum.sv | 221 ++++++++++++++++++++++
 tb/tb_visaccum.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/visaccum_pkg.sv
// visaccum_pkg: shared header for the correlator chain tail and its readout.
// Holds the default geometry, the width helper and the drain FSM state type.
// Output words are packed {im, re}: imaginary part in the upper VBITS bits,
// real part in the lower VBITS bits.
package visaccum_pkg;

    localparam int DEF_ABITS = 4;
    localparam int DEF_VBITS = 24;
    localparam int DEF_COUNT = 64;
    localparam int DEF_ACCUM = 1024;

    // Bits needed to hold 0..n-1. The result is never below 1, so it is
    // always a legal vector width, even for a single-frame block (ACCUM=1).
    function automatic int clog2(input int n);
        int bits;
        int v;
        bits = 0;
        v = n - 1;
        while (v > 0) begin
            bits++;
            v = v >> 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

    // Drain side of the ping-pong: wait for a full bank, prime the RAM read,
    // then present words until the last slot is accepted.
    typedef enum logic [1:0] {
        DR_IDLE    = 2'd0,
        DR_READ    = 2'd1,
        DR_PRESENT = 2'd2
    } drain_state_t;

endpackage

// File: rtl/visaccum_visram.sv
// visram: simple-dual-port RAM for one accumulator bank.
// One write port and one registered read port with a read enable, so the
// read data holds its value between reads (the drainer relies on that to keep
// m_tdata stable while the consumer stalls).
module visram
    import visaccum_pkg::*;
#(
    parameter int WIDTH = 2 * DEF_VBITS,
    parameter int DEPTH = DEF_COUNT,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port and registered read port share one clocked process.
    // NOTE: the storage array and its read register carry no reset; a reset
    // would turn the array into flops, and the first frame of every block
    // overwrites the contents anyway.
    // NOTE: clocked state is always assigned with <=, so every reader of mem
    // or rdata in this cycle sees the pre-edge value.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/visaccum.sv
// visaccum: chain-tail visibility accumulator.
// Sums each of COUNT visibility slots over ACCUM frames into one of two RAM
// banks. When a block completes and the other bank has finished draining, the
// banks swap and the full one is streamed out over m_tvalid/m_tready while the
// other starts the next block. The input side is never stalled; a block that
// completes while the drain is still busy is dropped and flagged.
module visaccum
    import visaccum_pkg::*;
#(
    parameter int ABITS = DEF_ABITS,
    parameter int VBITS = DEF_VBITS,
    parameter int COUNT = DEF_COUNT,
    parameter int CBITS = clog2(COUNT),
    parameter int ACCUM = DEF_ACCUM,
    parameter int FBITS = clog2(ACCUM)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               valid_i,
    input  logic [ABITS-1:0]   revis_i,
    input  logic [ABITS-1:0]   imvis_i,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic [2*VBITS-1:0] m_tdata,
    output logic               m_tlast,
    output logic               overrun_o,
    output logic               bank_o
);

    localparam int               EXT        = VBITS - ABITS;
    localparam logic [CBITS-1:0] SLOT_LAST  = CBITS'(COUNT - 1);
    localparam logic [FBITS-1:0] FRAME_LAST = FBITS'(ACCUM - 1);

    // Input position within the current block.
    logic [CBITS-1:0] slot;
    logic [FBITS-1:0] frame;

    // Block-completion decision for the current beat.
    logic drain_idle;
    logic block_done;
    logic swap;

    // Second stage of the read-modify-write: the beat registered alongside
    // the RAM read it triggered.
    logic             acc_valid;
    logic             acc_first;
    logic             acc_bank;
    logic [CBITS-1:0] acc_slot;
    logic [VBITS-1:0] acc_re;
    logic [VBITS-1:0] acc_im;
    logic [2*VBITS-1:0] acc_rdata;
    logic [VBITS-1:0] sum_re;
    logic [VBITS-1:0] sum_im;
    logic [2*VBITS-1:0] wr_data;

    // Drain side.
    drain_state_t     state;
    logic [CBITS-1:0] drain_idx;
    logic             drain_rd;
    logic [CBITS-1:0] drain_addr;

    // Per-bank RAM ports.
    logic [1:0]         ram_we;
    logic [1:0]         ram_re;
    logic [CBITS-1:0]   ram_raddr [2];
    logic [2*VBITS-1:0] ram_rdata [2];

    // Decide whether this beat closes a block and whether the banks can swap.
    // A drain whose last word is accepted this very cycle counts as idle.
    always_comb begin
        drain_idle = (state == DR_IDLE) ||
                     (state == DR_PRESENT && m_tready && drain_idx == SLOT_LAST);
        block_done = valid_i && (slot == SLOT_LAST) && (frame == FRAME_LAST);
        swap       = block_done && drain_idle;
    end

    // Slot/frame counters, bank selection and the sticky overrun flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            slot      <= '0;
            frame     <= '0;
            bank_o    <= 1'b0;
            overrun_o <= 1'b0;
            acc_valid <= 1'b0;
        end else begin
            acc_valid <= valid_i;
            if (valid_i) begin
                if (slot == SLOT_LAST) begin
                    slot <= '0;
                    if (frame == FRAME_LAST) begin
                        frame <= '0;
                        if (swap) begin
                            bank_o <= ~bank_o;
                        end else begin
                            // Drain still busy: keep the bank; the next frame
                            // overwrites the block that could not be handed off.
                            overrun_o <= 1'b1;
                        end
                    end else begin
                        frame <= frame + 1'b1;
                    end
                end else begin
                    slot <= slot + 1'b1;
                end
            end
        end
    end

    // Register the sign-extended beat next to the RAM read it launches.
    always_ff @(posedge clock) begin
        if (valid_i) begin
            acc_slot  <= slot;
            acc_first <= (frame == '0);
            acc_bank  <= bank_o;
            acc_re    <= {{EXT{revis_i[ABITS-1]}}, revis_i};
            acc_im    <= {{EXT{imvis_i[ABITS-1]}}, imvis_i};
        end
    end

    assign acc_rdata = ram_rdata[acc_bank];

    // Write-back value: overwrite on the first frame, otherwise add modulo
    // 2^VBITS with re and im kept independent.
    // NOTE: every signal written here gets a value on every path, so no
    // latch can be inferred.
    always_comb begin
        sum_re  = acc_rdata[VBITS-1:0] + acc_re;
        sum_im  = acc_rdata[2*VBITS-1:VBITS] + acc_im;
        wr_data = acc_first ? {acc_im, acc_re} : {sum_im, sum_re};
    end

    // Drain read request: prime slot 0 in READ, then fetch the next slot in
    // the same cycle a word is accepted so a held-high m_tready gets one word
    // per cycle.
    always_comb begin
        drain_rd   = 1'b0;
        drain_addr = drain_idx;
        if (state == DR_READ) begin
            drain_rd = 1'b1;
        end else if (state == DR_PRESENT && m_tready && drain_idx != SLOT_LAST) begin
            drain_rd   = 1'b1;
            drain_addr = drain_idx + 1'b1;
        end
    end

    // Route each bank's read port to the accumulator when active, else to
    // the drainer; writes always come from the accumulator pipeline.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            if (bank_o == 1'(b)) begin
                ram_re[b]    = valid_i;
                ram_raddr[b] = slot;
            end else begin
                ram_re[b]    = drain_rd;
                ram_raddr[b] = drain_addr;
            end
            ram_we[b] = acc_valid && (acc_bank == 1'(b));
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        visram #(
            .WIDTH (2 * VBITS),
            .DEPTH (COUNT),
            .AW    (CBITS)
        ) u_ram (
            .clock (clock),
            .we    (ram_we[b]),
            .waddr (acc_slot),
            .wdata (wr_data),
            .re    (ram_re[b]),
            .raddr (ram_raddr[b]),
            .rdata (ram_rdata[b])
        );
    end

    // The draining bank is always the one not accumulating; its read
    // register only moves on a drain read, so the word holds while stalled.
    assign m_tdata = ram_rdata[~bank_o];

    // Drain FSM with registered m_tvalid/m_tlast.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= DR_IDLE;
            drain_idx <= '0;
            m_tvalid  <= 1'b0;
            m_tlast   <= 1'b0;
        end else if (swap) begin
            state     <= DR_READ;
            drain_idx <= '0;
            m_tvalid  <= 1'b0;
            m_tlast   <= 1'b0;
        end else begin
            unique case (state)
                DR_READ: begin
                    state    <= DR_PRESENT;
                    m_tvalid <= 1'b1;
                    m_tlast  <= (drain_idx == SLOT_LAST);
                end
                DR_PRESENT: begin
                    if (m_tready) begin
                        if (drain_idx == SLOT_LAST) begin
                            state    <= DR_IDLE;
                            m_tvalid <= 1'b0;
                            m_tlast  <= 1'b0;
                        end else begin
                            drain_idx <= drain_addr;
                            m_tlast   <= (drain_addr == SLOT_LAST);
                        end
                    end
                end
                default: begin
                    state    <= DR_IDLE;
                    m_tvalid <= 1'b0;
                    m_tlast  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_visaccum.sv
// tb_visaccum: directed scoreboard bench for visaccum.
// Instance A: COUNT=4, ACCUM=1, VBITS=24. Instance B: COUNT=4, ACCUM=3, VBITS=5.
// Stimulus pushes expected words into a per-instance queue; a monitor pops and
// compares on every accepted word and checks that stalled words stay put.
module tb_visaccum;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset_a, reset_b;
    logic       valid_a, valid_b;
    logic [3:0] revis_a, imvis_a, revis_b, imvis_b;
    logic       ready_a, ready_b;
    logic       tvalid_a, tvalid_b, tlast_a, tlast_b;
    logic       overrun_a, overrun_b, bank_a, bank_b;
    logic [47:0] tdata_a;
    logic [9:0]  tdata_b;

    visaccum #(.ABITS(4), .VBITS(24), .COUNT(4), .ACCUM(1)) dut_a (
        .clock(clock), .reset(reset_a), .valid_i(valid_a),
        .revis_i(revis_a), .imvis_i(imvis_a),
        .m_tvalid(tvalid_a), .m_tready(ready_a), .m_tdata(tdata_a),
        .m_tlast(tlast_a), .overrun_o(overrun_a), .bank_o(bank_a)
    );

    visaccum #(.ABITS(4), .VBITS(5), .COUNT(4), .ACCUM(3)) dut_b (
        .clock(clock), .reset(reset_b), .valid_i(valid_b),
        .revis_i(revis_b), .imvis_i(imvis_b),
        .m_tvalid(tvalid_b), .m_tready(ready_b), .m_tdata(tdata_b),
        .m_tlast(tlast_b), .overrun_o(overrun_b), .bank_o(bank_b)
    );

    typedef struct {
        logic [47:0] data;
        logic        last;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Expected words: re/im are the true sums, truncated to the bank width.
    task automatic push_a(input int re, input int im, input logic last);
        exp_t e;
        e.data = {24'(im), 24'(re)};
        e.last = last;
        exp_a.push_back(e);
    endtask

    task automatic push_b(input int re, input int im, input logic last);
        exp_t e;
        e.data = {38'd0, 5'(im), 5'(re)};
        e.last = last;
        exp_b.push_back(e);
    endtask

    task automatic drive_a(input logic v, input int re, input int im);
        @(posedge clock);
        #1;
        valid_a = v;
        revis_a = 4'(re);
        imvis_a = 4'(im);
    endtask

    task automatic drive_b(input logic v, input int re, input int im, input logic rdy);
        @(posedge clock);
        #1;
        valid_b = v;
        revis_b = 4'(re);
        imvis_b = 4'(im);
        ready_b = rdy;
    endtask

    task automatic wait_drain_a(input string name);
        int n;
        n = 0;
        while ((exp_a.size() != 0 || tvalid_a) && n < 200) begin
            @(negedge clock);
            n++;
        end
        check(name, exp_a.size(), 0);
    endtask

    task automatic wait_drain_b(input string name);
        int n;
        n = 0;
        while ((exp_b.size() != 0 || tvalid_b) && n < 200) begin
            @(negedge clock);
            n++;
        end
        check(name, exp_b.size(), 0);
    endtask

    // Monitor A: compare accepted words, and check held words stay stable.
    logic        hold_a = 1'b0;
    logic [47:0] held_data_a;
    logic        held_last_a;
    always @(negedge clock) begin
        exp_t e;
        if (reset_a) begin
            hold_a = 1'b0;
        end else begin
            if (hold_a) begin
                check("a_hold_valid", tvalid_a, 1);
                check("a_hold_data", tdata_a, held_data_a);
                check("a_hold_last", tlast_a, held_last_a);
            end
            if (tvalid_a && ready_a) begin
                if (exp_a.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL a_extra_word: got %0h, no word expected", tdata_a);
                end else begin
                    e = exp_a.pop_front();
                    check("a_data", tdata_a, e.data);
                    check("a_last", tlast_a, e.last);
                end
            end
            hold_a      = tvalid_a && !ready_a;
            held_data_a = tdata_a;
            held_last_a = tlast_a;
        end
    end

    // Monitor B: same scheme for the narrow instance.
    logic       hold_b = 1'b0;
    logic [9:0] held_data_b;
    logic       held_last_b;
    always @(negedge clock) begin
        exp_t e;
        if (reset_b) begin
            hold_b = 1'b0;
        end else begin
            if (hold_b) begin
                check("b_hold_valid", tvalid_b, 1);
                check("b_hold_data", tdata_b, held_data_b);
                check("b_hold_last", tlast_b, held_last_b);
            end
            if (tvalid_b && ready_b) begin
                if (exp_b.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL b_extra_word: got %0h, no word expected", tdata_b);
                end else begin
                    e = exp_b.pop_front();
                    check("b_data", tdata_b, e.data);
                    check("b_last", tlast_b, e.last);
                end
            end
            hold_b      = tvalid_b && !ready_b;
            held_data_b = tdata_b;
            held_last_b = tlast_b;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   sre [4];
        int   sim [4];
        int   r, i;
        int   zeros;
        logic rdy;

        reset_a = 1'b1; reset_b = 1'b1;
        valid_a = 1'b0; valid_b = 1'b0;
        revis_a = '0; imvis_a = '0; revis_b = '0; imvis_b = '0;
        ready_a = 1'b0; ready_b = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset_a = 1'b0;
        reset_b = 1'b0;
        @(negedge clock);
        check("a_rst_tvalid", tvalid_a, 0);
        check("a_rst_tlast", tlast_a, 0);
        check("a_rst_overrun", overrun_a, 0);
        check("a_rst_bank", bank_a, 0);
        check("b_rst_tvalid", tvalid_b, 0);
        check("b_rst_tlast", tlast_b, 0);
        check("b_rst_overrun", overrun_b, 0);
        check("b_rst_bank", bank_b, 0);

        // A1: single-frame block, words are the sign-extended inputs.
        ready_a = 1'b1;
        push_a(1, 0, 0); push_a(2, -2, 0); push_a(3, 7, 0); push_a(-1, -8, 1);
        drive_a(1, 1, 0); drive_a(1, 2, -2); drive_a(1, 3, 7); drive_a(1, -1, -8);
        drive_a(0, 0, 0);
        @(negedge clock);
        check("a_bank_toggle", bank_a, 1);
        wait_drain_a("a_t1_drained");

        // A2: one idle cycle between blocks makes each last accept coincide
        // with the next block's final beat; every block must still swap.
        for (int blk = 0; blk < 3; blk++) begin
            for (int s = 0; s < 4; s++) begin
                push_a(blk * 3 + s - 4, 3 - s - blk, s == 3);
                drive_a(1, blk * 3 + s - 4, 3 - s - blk);
            end
            drive_a(0, 0, 0);
        end
        wait_drain_a("a_coincide_drained");
        check("a_coincide_overrun", overrun_a, 0);
        check("a_coincide_bank", bank_a, 0);

        // A3: consumer stalled while two more blocks complete.
        ready_a = 1'b0;
        for (int s = 0; s < 4; s++) begin
            push_a(s * 2 - 3, s - 6, s == 3);
            drive_a(1, s * 2 - 3, s - 6);
        end
        repeat (4) drive_a(0, 0, 0);
        @(negedge clock);
        check("a_pre_overrun", overrun_a, 0);
        check("a_pre_bank", bank_a, 1);
        check("a_stall_tvalid", tvalid_a, 1);
        check("a_stall_word0", tdata_a, {24'hFFFFFA, 24'hFFFFFD});
        for (int s = 0; s < 4; s++) drive_a(1, 5, 5);
        repeat (2) drive_a(0, 0, 0);
        @(negedge clock);
        check("a_overrun_set", overrun_a, 1);
        check("a_overrun_bank", bank_a, 1);
        for (int s = 0; s < 4; s++) drive_a(1, -7, 6);
        repeat (2) drive_a(0, 0, 0);
        @(negedge clock);
        check("a_held_word0", tdata_a, {24'hFFFFFA, 24'hFFFFFD});
        check("a_held_last", tlast_a, 0);
        ready_a = 1'b1;
        wait_drain_a("a_overrun_drained");
        check("a_overrun_sticky", overrun_a, 1);

        // B1: -8 over 3 frames is -24, which wraps to +8 in 5 bits.
        for (int s = 0; s < 4; s++) push_b(-24, -24, s == 3);
        for (int k = 0; k < 12; k++) drive_b(1, -8, -8, 1);
        drive_b(0, 0, 0, 1);
        wait_drain_b("b_neg_drained");
        check("b_neg_bank", bank_b, 1);

        // B2: 7 over 3 frames is 21, which wraps to -11 in 5 bits; im = -3.
        for (int s = 0; s < 4; s++) push_b(21, -3, s == 3);
        for (int k = 0; k < 12; k++) drive_b(1, 7, -1, 1);
        drive_b(0, 0, 0, 1);
        wait_drain_b("b_wrap_drained");
        check("b_wrap_overrun", overrun_b, 0);
        check("b_wrap_bank", bank_b, 0);

        // B3: ten back-to-back blocks of random data, random m_tready with at
        // most one stalled cycle in a row so every drain fits in a block.
        zeros = 0;
        for (int blk = 0; blk < 10; blk++) begin
            for (int s = 0; s < 4; s++) begin
                sre[s] = 0;
                sim[s] = 0;
            end
            for (int f = 0; f < 3; f++) begin
                for (int s = 0; s < 4; s++) begin
                    r = int'($urandom_range(0, 15));
                    i = int'($urandom_range(0, 15));
                    if (r >= 8) r = r - 16;
                    if (i >= 8) i = i - 16;
                    sre[s] += r;
                    sim[s] += i;
                    if (f == 2 && s == 3) begin
                        for (int q = 0; q < 4; q++) push_b(sre[q], sim[q], q == 3);
                    end
                    if (zeros >= 1) rdy = 1'b1;
                    else rdy = 1'($urandom_range(0, 1));
                    zeros = rdy ? 0 : zeros + 1;
                    drive_b(1, r, i, rdy);
                end
            end
        end
        drive_b(0, 0, 0, 1);
        wait_drain_b("b_random_drained");
        check("b_random_overrun", overrun_b, 0);
        check("b_random_bank", bank_b, 0);

        // B4: reset while word 2 of a block is on the bus and the next block
        // is partly accumulated.
        for (int s = 0; s < 4; s++) push_b(3, 3, s == 3);
        for (int k = 0; k < 12; k++) drive_b(1, 1, 1, 0);
        for (int k = 0; k < 4; k++) drive_b(1, 5, 5, 0);
        drive_b(0, 0, 0, 1);
        drive_b(0, 0, 0, 1);
        drive_b(0, 0, 0, 0);
        @(negedge clock);
        check("b_mid_tvalid", tvalid_b, 1);
        check("b_mid_pending", exp_b.size(), 2);
        check("b_mid_bank", bank_b, 1);
        @(posedge clock);
        #1;
        reset_b = 1'b1;
        exp_b.delete();
        @(posedge clock);
        #1;
        reset_b = 1'b0;
        @(negedge clock);
        check("b_abort_tvalid", tvalid_b, 0);
        check("b_abort_bank", bank_b, 0);
        check("b_abort_overrun", overrun_b, 0);
        for (int s = 0; s < 4; s++) push_b(6, -9, s == 3);
        for (int k = 0; k < 12; k++) drive_b(1, 2, -3, 1);
        drive_b(0, 0, 0, 1);
        wait_drain_b("b_fresh_drained");
        check("b_fresh_bank", bank_b, 1);

        repeat (4) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
